// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults and loader state encoding for the fir filter family
package fir_pkg;

    localparam int FirDataWidth = 12;
    localparam int FirNTaps = 9;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        DRAIN
    } loader_state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: NCoeffs x DataWidth coefficient register file with flattened parallel read
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int DataWidth = FirDataWidth,
    parameter int NCoeffs = (FirNTaps + 1) / 2,
    parameter int AddrWidth = $clog2(NCoeffs)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [AddrWidth-1:0]          wr_addr,
    input  logic signed [DataWidth-1:0]   wr_data,
    output logic [NCoeffs*DataWidth-1:0]  rd_all
);

    logic [DataWidth-1:0] mem [NCoeffs];

    // Addresses at or beyond NCoeffs match no entry and are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCoeffs; k++) mem[k] <= '0;
        end else begin
            for (int k = 0; k < NCoeffs; k++)
                if (wr_en && wr_addr == AddrWidth'(k)) mem[k] <= wr_data;
        end
    end

    for (genvar i = 0; i < NCoeffs; i++) begin : g_rd
        assign rd_all[i*DataWidth +: DataWidth] = mem[i];
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams a snapshot of the coefficient bank bit-serially into the fir
// coefficient chain and gates the filter start so loads never overlap a MAC run
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int DataWidth = FirDataWidth,
    parameter int NTaps = FirNTaps
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [$clog2((NTaps + 1) / 2)-1:0]   wr_addr,
    input  logic signed [DataWidth-1:0]          wr_data,
    input  logic                                 load_req,
    input  logic                                 start_in,
    input  logic                                 fir_done,
    output logic                                 start_out,
    output logic                                 coeff_load_out,
    output logic                                 coeff_out,
    output logic                                 busy,
    output logic                                 load_done,
    output logic                                 start_dropped
);

    localparam int NCoeffs = (NTaps + 1) / 2;
    localparam int TotalBits = NCoeffs * DataWidth;
    localparam int CntWidth = $clog2(TotalBits);

    loader_state_e state;
    logic pending;
    logic fir_active;
    logic go_shift;
    logic [TotalBits-1:0] bank_flat;
    logic [TotalBits-1:0] snap;
    logic [CntWidth-1:0] cnt;

    fir_coeff_bank #(
        .DataWidth(DataWidth),
        .NCoeffs(NCoeffs)
    ) u_bank (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_all(bank_flat)
    );

    // A done pulse frees the filter in the same cycle, so a start may pass alongside it
    assign start_out = !rst && start_in && state == IDLE && (!fir_active || fir_done);
    assign start_dropped = !rst && start_in && !start_out;
    assign busy = state != IDLE || pending;
    assign coeff_out = coeff_load_out & snap[TotalBits-1];
    assign go_shift = (state == IDLE) ? (pending && !fir_active && !start_in)
                                      : (state == WAIT && (!fir_active || fir_done));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pending <= 1'b0;
            fir_active <= 1'b0;
            snap <= '0;
            cnt <= '0;
            coeff_load_out <= 1'b0;
            load_done <= 1'b0;
        end else begin
            pending <= load_req || (pending && !go_shift);
            fir_active <= start_out || (fir_active && !fir_done);
            load_done <= 1'b0;
            if (go_shift) begin
                state <= SHIFT;
                snap <= bank_flat;
                cnt <= '0;
                coeff_load_out <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (pending && fir_active) state <= WAIT;
                    SHIFT: begin
                        snap <= snap << 1;
                        cnt <= cnt + 1'b1;
                        if (cnt == CntWidth'(TotalBits - 1)) begin
                            state <= DRAIN;
                            coeff_load_out <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                    DRAIN: state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed checks of bank transfer, load/start arbitration, coalescing and reset
module tb_fir_coeff_loader;

    localparam int TB = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic signed [11:0] wr_data = '0;
    logic load_req = 1'b0;
    logic start_in = 1'b0;
    logic fir_done = 1'b0;
    logic start_out, coeff_load_out, coeff_out, busy, load_done, start_dropped;

    logic [TB-1:0] chain = '0;
    int n_bits = 0, n_done = 0, n_drop = 0, n_leak = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fir_coeff_loader dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .load_req(load_req),
        .start_in(start_in),
        .fir_done(fir_done),
        .start_out(start_out),
        .coeff_load_out(coeff_load_out),
        .coeff_out(coeff_out),
        .busy(busy),
        .load_done(load_done),
        .start_dropped(start_dropped)
    );

    // Models the filter's coefficient shift chain: first bit ends up at the top
    always @(negedge clk) begin
        if (coeff_load_out) begin
            chain = {chain[TB-2:0], coeff_out};
            n_bits++;
        end
        if (!coeff_load_out && coeff_out) n_leak++;
        if (load_done) n_done++;
        if (start_dropped) n_drop++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        chain = '0;
        n_bits = 0;
        n_done = 0;
        n_drop = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [11:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !load_done; i++) tick();
        chk(tag, load_done, 1);
    endtask

    initial begin
        #1;
        chk("rst_outs", {start_out, coeff_load_out, coeff_out, busy, load_done, start_dropped}, 0);
        start_in = 1'b1;
        #1 chk("rst_start_gate", {start_out, start_dropped}, 0);
        start_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Bank transfer with the filter idle
        wr(0, 12'h001); wr(1, 12'h7FF); wr(2, 12'h800); wr(3, 12'h123); wr(4, 12'hABC);
        wr(7, 12'hFFF);
        clr_mon();
        req();
        chk("pend_busy", busy, 1);
        chk("lat_no_bit", coeff_load_out, 0);
        tick();
        chk("first_bit", {coeff_load_out, coeff_out}, 2'b11);
        wait_done("done1");
        tick();
        tick();
        chk("bits1", n_bits, 60);
        chk("chain1", chain, 60'hABC_123_800_7FF_001);
        chk("coeff2", chain[35:24], 12'h800);
        chk("done_cnt1", n_done, 1);
        chk("idle1", busy, 0);

        // Load waits for a running filter
        clr_mon();
        start_in = 1'b1;
        #1 chk("fwd_start", {start_out, start_dropped}, 2'b10);
        tick();
        start_in = 1'b0;
        tick();
        tick();
        req();
        tick();
        chk("wait_hold", {coeff_load_out, busy}, 2'b01);
        start_in = 1'b1;
        #1 chk("wait_drop", {start_out, start_dropped}, 2'b01);
        tick();
        start_in = 1'b0;
        chk("wait_still", coeff_load_out, 0);
        fir_done = 1'b1;
        #1 chk("done_cycle", coeff_load_out, 0);
        tick();
        fir_done = 1'b0;
        chk("shift_after_done", {coeff_load_out, coeff_out}, 2'b11);
        wait_done("done2");
        tick();
        tick();
        chk("chain2", chain, 60'hABC_123_800_7FF_001);
        chk("drop_cnt2", n_drop, 1);

        // Starts blocked during SHIFT and DRAIN, forwarded right after
        clr_mon();
        req();
        tick();
        repeat (20) tick();
        start_in = 1'b1;
        #1 chk("shift_drop", {start_out, start_dropped}, 2'b01);
        tick();
        start_in = 1'b0;
        wait_done("done3");
        start_in = 1'b1;
        #1 chk("drain_drop", {start_out, start_dropped}, 2'b01);
        tick();
        chk("post_drain_fwd", {start_out, start_dropped}, 2'b10);
        tick();
        chk("active_drop", {start_out, start_dropped}, 2'b01);
        fir_done = 1'b1;
        #1 chk("done_fwd", {start_out, start_dropped}, 2'b10);
        tick();
        start_in = 1'b0;
        fir_done = 1'b0;
        start_in = 1'b1;
        #1 chk("set_wins", {start_out, start_dropped}, 2'b01);
        start_in = 1'b0;
        fir_done = 1'b1;
        tick();
        fir_done = 1'b0;
        chk("drop_cnt3", n_drop, 2);

        // Coalesced requests and a bank write during SHIFT
        clr_mon();
        req();
        tick();
        repeat (5) tick();
        req();
        tick();
        req();
        wr(2, 12'h555);
        req();
        wr(6, 12'h3AA);
        wait_done("done4");
        chk("bits4", n_bits, 60);
        chk("chain4", chain, 60'hABC_123_800_7FF_001);
        tick();
        chk("pend_after", {busy, coeff_load_out}, 2'b10);
        clr_mon();
        tick();
        chk("second_load", {coeff_load_out, coeff_out}, 2'b11);
        wait_done("done5");
        tick();
        tick();
        chk("bits5", n_bits, 60);
        chk("chain5", chain, 60'hABC_123_555_7FF_001);
        chk("done_cnt5", n_done, 1);
        chk("idle5", busy, 0);

        // Reset mid-SHIFT
        clr_mon();
        req();
        tick();
        repeat (30) tick();
        start_in = 1'b1;
        rst = 1'b1;
        #1 chk("rst_async", {coeff_load_out, coeff_out, busy, start_out, load_done, start_dropped}, 0);
        start_in = 1'b0;
        tick();
        rst = 1'b0;
        clr_mon();
        req();
        tick();
        chk("rst_reload", coeff_load_out, 1);
        wait_done("done6");
        tick();
        tick();
        chk("bits6", n_bits, 60);
        chk("chain_zero", chain, 0);

        // Impulse coefficient set on the middle tap
        wr(4, 12'h7FF);
        clr_mon();
        req();
        tick();
        wait_done("done7");
        tick();
        tick();
        chk("chain_impulse", chain, 60'h7FF_000_000_000_000);
        chk("leak", n_leak, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
